scan_decoder: RTL

Registered, parametrised N-to-2^N one-hot decoder with an optional auto-scan sequencer. It is the next generation of the lab's 3-to-8 select decoder. It drives digit or row enables for multiplexed displays and LED banks. In direct mode the select index is loaded from the `S` input. In scan mode the index advances through every output on a programmable prescaler tick.

---
 rtl/scan_decoder.sv | 84 ++++++++
 1 files changed

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with an optional auto-scan sequencer.
// The scan sequencer and prescaler are built only when SCAN_DECODER_AUTOSCAN_EN is defined.
module scan_decoder #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                load,
  input  logic [SEL_W-1:0]    S,
  input  logic [DIV_W-1:0]    div,
  output logic [2**SEL_W-1:0] Out,
  output logic [SEL_W-1:0]    Idx,
  output logic                wrap
);
  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  logic [OUT_W-1:0] out_q, out_d;
  logic [SEL_W-1:0] idx_q, idx_d, idx_next;
  logic             wrap_q, wrap_d;

`ifdef SCAN_DECODER_AUTOSCAN_EN
  logic [DIV_W-1:0] pre_q, pre_d;
`else
  wire unused_scan_in = ^{mode, div};
`endif

  always_comb begin
    idx_next = idx_q;
    idx_d    = idx_q;
    out_d    = '0;
    wrap_d   = 1'b0;
`ifdef SCAN_DECODER_AUTOSCAN_EN
    pre_d    = pre_q;
`endif
    if (en) begin
`ifdef SCAN_DECODER_AUTOSCAN_EN
      if (mode) begin
        // >= so that lowering div below the running count steps at once
        if (pre_q >= div) begin
          pre_d    = '0;
          idx_next = idx_q + SEL_W'(1);
          wrap_d   = &idx_q;
        end else begin
          pre_d    = pre_q + DIV_W'(1);
        end
      end else begin
        pre_d = '0;
        if (load) idx_next = S;
      end
`else
      if (load) idx_next = S;
`endif
      idx_d = idx_next;
      out_d = ONE << idx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
`ifdef SCAN_DECODER_AUTOSCAN_EN
      pre_q  <= '0;
`endif
    end else begin
      out_q  <= out_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
`ifdef SCAN_DECODER_AUTOSCAN_EN
      pre_q  <= pre_d;
`endif
    end
  end

  assign Out  = out_q;
  assign Idx  = idx_q;
  assign wrap = wrap_q;

endmodule
